// File: rtl/csr_ctrl_pkg.sv
// Shared register-width and CSR definitions for the CSR access controller.
// Operation encodings, supported CSR addresses and the read-modify-write helper live here.
package reg_defines;
  localparam int REG_W_END = 31;
endpackage

package csr_defines;
  import reg_defines::*;

  localparam int REG_W = REG_W_END + 1;

  typedef enum logic [1:0] {
    CSR_OP_RSVD = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } csr_state_t;

  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  function automatic logic csrKnown(input logic [11:0] addr);
    return (addr == CSR_MISA)    || (addr == CSR_MVENDORID) ||
           (addr == CSR_MARCHID) || (addr == CSR_MCYCLE)    ||
           (addr == CSR_MCYCLEH) || (addr == CSR_MINSTRET)  ||
           (addr == CSR_MINSTRETH);
  endfunction

  // Bitwise set/clear only; reserved op leaves the value untouched (it is rejected anyway).
  function automatic logic [REG_W-1:0] csrNewValue(input csr_op_t op,
                                                   input logic [REG_W-1:0] oldValue,
                                                   input logic [REG_W-1:0] operand);
    case (op)
      CSR_OP_RW: return operand;
      CSR_OP_RS: return oldValue | operand;
      CSR_OP_RC: return oldValue & ~operand;
      default:   return oldValue;
    endcase
  endfunction
endpackage

// File: rtl/csr_ctrl_arb.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins.
module csr_rr_arb (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_grant
);
  logic r_lastDbg;

  always_comb begin
    o_grant = 2'b00;
    if (i_en) begin
      if (i_req == 2'b11) o_grant = r_lastDbg ? 2'b01 : 2'b10;
      else                o_grant = i_req;
    end
  end

  // Starts as "debug granted last" so the core wins the first tie.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)            r_lastDbg <= 1'b1;
    else if (|o_grant)    r_lastDbg <= o_grant[1];
  end
endmodule

// File: rtl/csr_ctrl.sv
// CSR access controller: arbitrates core/debug requests and performs
// read-modify-write sequences on a single CSR file port.
module csr_ctrl
  import csr_defines::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             core_req_valid,
  output logic             core_req_ready,
  input  logic [1:0]       core_req_op,
  input  logic [11:0]      core_req_addr,
  input  logic [REG_W-1:0] core_req_wdata,
  input  logic             core_req_nowrite,
  output logic             core_rsp_valid,
  output logic [REG_W-1:0] core_rsp_rdata,
  output logic             core_rsp_illegal,
  input  logic             dbg_req_valid,
  output logic             dbg_req_ready,
  input  logic [1:0]       dbg_req_op,
  input  logic [11:0]      dbg_req_addr,
  input  logic [REG_W-1:0] dbg_req_wdata,
  input  logic             dbg_req_nowrite,
  output logic             dbg_rsp_valid,
  output logic [REG_W-1:0] dbg_rsp_rdata,
  output logic             dbg_rsp_illegal,
  output logic [11:0]      csr_addr,
  output logic             csr_wen,
  output logic [REG_W-1:0] csr_wdata,
  input  logic [REG_W-1:0] csr_rdata
);
  csr_state_t       r_state;
  logic             r_ownerDbg;
  csr_op_t          r_op;
  logic [11:0]      r_addr;
  logic [REG_W-1:0] r_operand;
  logic             r_nowrite;
  logic [REG_W-1:0] r_old;
  logic             r_csrWen;
  logic [REG_W-1:0] r_csrWdata;
  logic             r_coreRspValid, r_coreRspIllegal;
  logic [REG_W-1:0] r_coreRspRdata;
  logic             r_dbgRspValid, r_dbgRspIllegal;
  logic [REG_W-1:0] r_dbgRspRdata;

  logic [1:0]       w_grant;
  logic             w_writeIntent;
  logic             w_illegal;
  logic             w_goWrite;
  logic [REG_W-1:0] w_newValue;
  logic             w_rspFire;
  logic [REG_W-1:0] w_rspRdata;
  logic             w_rspIllegal;

  csr_rr_arb u_arb (
    .clock   (clock),
    .reset   (reset),
    .i_req   ({dbg_req_valid, core_req_valid}),
    .i_en    (r_state == ST_IDLE),
    .o_grant (w_grant)
  );

  assign core_req_ready = w_grant[0];
  assign dbg_req_ready  = w_grant[1];

  assign w_writeIntent = (r_op == CSR_OP_RW) ||
                         (((r_op == CSR_OP_RS) || (r_op == CSR_OP_RC)) && !r_nowrite);
  assign w_illegal     = (r_op == CSR_OP_RSVD) || !csrKnown(r_addr) ||
                         (w_writeIntent && (r_addr[11:10] == 2'b11));
  assign w_goWrite     = w_writeIntent && !w_illegal;
  assign w_newValue    = csrNewValue(r_op, csr_rdata, r_operand);

  // Response leaves READ directly for no-write/illegal accesses, otherwise after WRITE.
  assign w_rspFire    = ((r_state == ST_READ) && !w_goWrite) || (r_state == ST_WRITE);
  assign w_rspRdata   = (r_state == ST_WRITE) ? r_old : (w_illegal ? '0 : csr_rdata);
  assign w_rspIllegal = (r_state == ST_READ) && w_illegal;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_ownerDbg       <= 1'b0;
      r_op             <= CSR_OP_RSVD;
      r_addr           <= '0;
      r_operand        <= '0;
      r_nowrite        <= 1'b0;
      r_old            <= '0;
      r_csrWen         <= 1'b0;
      r_csrWdata       <= '0;
      r_coreRspValid   <= 1'b0;
      r_coreRspRdata   <= '0;
      r_coreRspIllegal <= 1'b0;
      r_dbgRspValid    <= 1'b0;
      r_dbgRspRdata    <= '0;
      r_dbgRspIllegal  <= 1'b0;
    end else begin
      r_csrWen         <= 1'b0;
      r_coreRspValid   <= w_rspFire && !r_ownerDbg;
      r_coreRspRdata   <= (w_rspFire && !r_ownerDbg) ? w_rspRdata : '0;
      r_coreRspIllegal <= w_rspFire && !r_ownerDbg && w_rspIllegal;
      r_dbgRspValid    <= w_rspFire && r_ownerDbg;
      r_dbgRspRdata    <= (w_rspFire && r_ownerDbg) ? w_rspRdata : '0;
      r_dbgRspIllegal  <= w_rspFire && r_ownerDbg && w_rspIllegal;

      case (r_state)
        ST_IDLE: begin
          if (|w_grant) begin
            r_ownerDbg <= w_grant[1];
            r_op       <= csr_op_t'(w_grant[1] ? dbg_req_op : core_req_op);
            r_addr     <= w_grant[1] ? dbg_req_addr : core_req_addr;
            r_operand  <= w_grant[1] ? dbg_req_wdata : core_req_wdata;
            r_nowrite  <= w_grant[1] ? dbg_req_nowrite : core_req_nowrite;
            r_state    <= ST_READ;
          end
        end
        ST_READ: begin
          r_old <= csr_rdata;
          if (w_goWrite) begin
            r_csrWen   <= 1'b1;
            r_csrWdata <= w_newValue;
            r_state    <= ST_WRITE;
          end else begin
            r_state    <= ST_RESP;
          end
        end
        ST_WRITE: r_state <= ST_RESP;
        ST_RESP:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign csr_addr         = r_addr;
  assign csr_wen          = r_csrWen;
  assign csr_wdata        = r_csrWdata;
  assign core_rsp_valid   = r_coreRspValid;
  assign core_rsp_rdata   = r_coreRspRdata;
  assign core_rsp_illegal = r_coreRspIllegal;
  assign dbg_rsp_valid    = r_dbgRspValid;
  assign dbg_rsp_rdata    = r_dbgRspRdata;
  assign dbg_rsp_illegal  = r_dbgRspIllegal;
endmodule

// File: tb/tb_csr_ctrl.sv
// Self-checking bench for csr_ctrl: table of single transactions plus
// hand-written arbitration, reset-abort and cancel sequences.
module tb_csr_ctrl;
  import csr_defines::*;

  logic             clock = 1'b0;
  logic             reset;
  logic             core_req_valid, core_req_ready, core_req_nowrite;
  logic [1:0]       core_req_op;
  logic [11:0]      core_req_addr;
  logic [REG_W-1:0] core_req_wdata;
  logic             core_rsp_valid, core_rsp_illegal;
  logic [REG_W-1:0] core_rsp_rdata;
  logic             dbg_req_valid, dbg_req_ready, dbg_req_nowrite;
  logic [1:0]       dbg_req_op;
  logic [11:0]      dbg_req_addr;
  logic [REG_W-1:0] dbg_req_wdata;
  logic             dbg_rsp_valid, dbg_rsp_illegal;
  logic [REG_W-1:0] dbg_rsp_rdata;
  logic [11:0]      csr_addr;
  logic             csr_wen;
  logic [REG_W-1:0] csr_wdata;
  logic [REG_W-1:0] csr_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  csr_ctrl dut (
    .clock(clock), .reset(reset),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_op(core_req_op), .core_req_addr(core_req_addr),
    .core_req_wdata(core_req_wdata), .core_req_nowrite(core_req_nowrite),
    .core_rsp_valid(core_rsp_valid), .core_rsp_rdata(core_rsp_rdata),
    .core_rsp_illegal(core_rsp_illegal),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
    .dbg_req_op(dbg_req_op), .dbg_req_addr(dbg_req_addr),
    .dbg_req_wdata(dbg_req_wdata), .dbg_req_nowrite(dbg_req_nowrite),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_rdata(dbg_rsp_rdata),
    .dbg_rsp_illegal(dbg_rsp_illegal),
    .csr_addr(csr_addr), .csr_wen(csr_wen), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata)
  );

  typedef struct {
    logic             isDbg;
    logic [1:0]       op;
    logic [11:0]      addr;
    logic [REG_W-1:0] wdata;
    logic             nowrite;
    logic [REG_W-1:0] rdIn;
    logic             expWen;
    logic [REG_W-1:0] expWdata;
    logic             expIll;
    logic [REG_W-1:0] expRdata;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic driveReq(input logic isDbg, input logic [1:0] op, input logic [11:0] addr,
                          input logic [REG_W-1:0] wdata, input logic nowrite);
    if (isDbg) begin
      dbg_req_valid = 1'b1; dbg_req_op = op; dbg_req_addr = addr;
      dbg_req_wdata = wdata; dbg_req_nowrite = nowrite;
    end else begin
      core_req_valid = 1'b1; core_req_op = op; core_req_addr = addr;
      core_req_wdata = wdata; core_req_nowrite = nowrite;
    end
  endtask

  task automatic doReset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // One transaction on one port; cycle c counts clocks after acceptance.
  task automatic applyStimulus(input vec_t v, input string tag);
    int   wenCount = 0, wenCycle = 0, rspCount = 0, rspCycle = 0;
    logic [REG_W-1:0] gotWdata = '0, gotRdata = '0;
    logic gotIll = 1'b0, otherBad = 1'b0, readyBad = 1'b0, idleBad = 1'b0;
    logic ownValid, ownIll, othValid, othIll;
    logic [REG_W-1:0] ownRdata, othRdata;
    @(negedge clock);
    csr_rdata = v.rdIn;
    driveReq(v.isDbg, v.op, v.addr, v.wdata, v.nowrite);
    #1;
    checkOutput({tag, " ready"}, {30'd0, dbg_req_ready, core_req_ready}, v.isDbg ? 32'd2 : 32'd1);
    @(posedge clock);
    #1;
    core_req_valid = 1'b0;
    dbg_req_valid  = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      if (c == 1) checkOutput({tag, " csr_addr"}, {20'd0, csr_addr}, {20'd0, v.addr});
      if (core_req_ready || dbg_req_ready) readyBad = 1'b1;
      if (csr_wen) begin wenCount++; wenCycle = c; gotWdata = csr_wdata; end
      ownValid = v.isDbg ? dbg_rsp_valid   : core_rsp_valid;
      ownRdata = v.isDbg ? dbg_rsp_rdata   : core_rsp_rdata;
      ownIll   = v.isDbg ? dbg_rsp_illegal : core_rsp_illegal;
      othValid = v.isDbg ? core_rsp_valid   : dbg_rsp_valid;
      othRdata = v.isDbg ? core_rsp_rdata   : dbg_rsp_rdata;
      othIll   = v.isDbg ? core_rsp_illegal : dbg_rsp_illegal;
      if (ownValid) begin
        rspCount++; rspCycle = c; gotRdata = ownRdata; gotIll = ownIll;
      end else if (ownRdata != '0 || ownIll) idleBad = 1'b1;
      if (othValid || othRdata != '0 || othIll) otherBad = 1'b1;
    end
    checkOutput({tag, " wen count"}, wenCount, v.expWen ? 32'd1 : 32'd0);
    if (v.expWen) begin
      checkOutput({tag, " wen cycle"}, wenCycle, 32'd2);
      checkOutput({tag, " csr_wdata"}, gotWdata, v.expWdata);
    end
    checkOutput({tag, " rsp count"}, rspCount, 32'd1);
    checkOutput({tag, " rsp latency"}, rspCycle, v.expWen ? 32'd3 : 32'd2);
    checkOutput({tag, " rsp rdata"}, gotRdata, v.expRdata);
    checkOutput({tag, " rsp illegal"}, {31'd0, gotIll}, {31'd0, v.expIll});
    checkOutput({tag, " other port quiet"}, {31'd0, otherBad}, 32'd0);
    checkOutput({tag, " own port quiet"}, {31'd0, idleBad}, 32'd0);
    checkOutput({tag, " ready low while busy"}, {31'd0, readyBad}, 32'd0);
  endtask

  initial begin
    int coreRspCycle, dbgRspCycle, coreRspCount, dbgRspCount, dbgGrantCycle;
    int wenCount;
    logic [REG_W-1:0] coreRdata, dbgRdata, wdata1, wdata2;
    logic quietBad;

    vecs[0]  = '{1'b0, 2'b01, 12'hB00, 32'h0000_1234, 1'b0, 32'h0000_0010, 1'b1, 32'h0000_1234, 1'b0, 32'h0000_0010};
    vecs[1]  = '{1'b0, 2'b10, 12'hB02, 32'h0000_0000, 1'b1, 32'h0000_0007, 1'b0, 32'h0,         1'b0, 32'h0000_0007};
    vecs[2]  = '{1'b1, 2'b01, 12'hF11, 32'h0000_0005, 1'b0, 32'h0000_00AA, 1'b0, 32'h0,         1'b1, 32'h0};
    vecs[3]  = '{1'b1, 2'b10, 12'h123, 32'h0000_0000, 1'b1, 32'h0000_0055, 1'b0, 32'h0,         1'b1, 32'h0};
    vecs[4]  = '{1'b0, 2'b11, 12'hB80, 32'h0000_00F0, 1'b0, 32'h0000_00FF, 1'b1, 32'h0000_000F, 1'b0, 32'h0000_00FF};
    vecs[5]  = '{1'b1, 2'b10, 12'h301, 32'h0000_0F00, 1'b0, 32'h0000_00F0, 1'b1, 32'h0000_0FF0, 1'b0, 32'h0000_00F0};
    vecs[6]  = '{1'b0, 2'b00, 12'hB00, 32'h0000_0001, 1'b0, 32'h0000_0033, 1'b0, 32'h0,         1'b1, 32'h0};
    vecs[7]  = '{1'b1, 2'b10, 12'hF12, 32'h0000_0000, 1'b1, 32'h0000_DEAD, 1'b0, 32'h0,         1'b0, 32'h0000_DEAD};
    vecs[8]  = '{1'b0, 2'b11, 12'hB82, 32'h0000_0000, 1'b1, 32'h0000_0003, 1'b0, 32'h0,         1'b0, 32'h0000_0003};
    vecs[9]  = '{1'b1, 2'b01, 12'hB00, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001};
    vecs[10] = '{1'b0, 2'b10, 12'hF11, 32'h0000_0100, 1'b0, 32'h0000_0044, 1'b0, 32'h0,         1'b1, 32'h0};

    reset = 1'b1;
    core_req_valid = 1'b0; core_req_op = 2'b00; core_req_addr = '0; core_req_wdata = '0; core_req_nowrite = 1'b0;
    dbg_req_valid  = 1'b0; dbg_req_op  = 2'b00; dbg_req_addr  = '0; dbg_req_wdata  = '0; dbg_req_nowrite  = 1'b0;
    csr_rdata = '0;

    @(negedge clock);
    checkOutput("reset csr_wen", {31'd0, csr_wen}, 32'd0);
    checkOutput("reset csr_addr", {20'd0, csr_addr}, 32'd0);
    checkOutput("reset csr_wdata", csr_wdata, 32'd0);
    checkOutput("reset rsp", {29'd0, core_rsp_valid, dbg_rsp_valid, core_rsp_illegal | dbg_rsp_illegal}, 32'd0);
    checkOutput("reset rsp rdata", core_rsp_rdata | dbg_rsp_rdata, 32'd0);
    checkOutput("reset ready", {30'd0, core_req_ready, dbg_req_ready}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Tie after reset: core first, debug next, each response only on its own port.
    doReset();
    @(negedge clock);
    csr_rdata = 32'h5;
    driveReq(1'b0, 2'b01, 12'hB00, 32'h11, 1'b0);
    driveReq(1'b1, 2'b01, 12'hB02, 32'h22, 1'b0);
    #1;
    checkOutput("tie first grant", {30'd0, dbg_req_ready, core_req_ready}, 32'd1);
    @(posedge clock);
    #1;
    core_req_valid = 1'b0;
    coreRspCycle = 0; dbgRspCycle = 0; coreRspCount = 0; dbgRspCount = 0; dbgGrantCycle = 0;
    wenCount = 0; coreRdata = '0; dbgRdata = '0; wdata1 = '0; wdata2 = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      if (core_rsp_valid) begin coreRspCount++; coreRspCycle = c; coreRdata = core_rsp_rdata; end
      if (dbg_rsp_valid)  begin dbgRspCount++;  dbgRspCycle  = c; dbgRdata  = dbg_rsp_rdata;  end
      if (csr_wen) begin
        wenCount++;
        if (wenCount == 1) wdata1 = csr_wdata; else wdata2 = csr_wdata;
      end
      if (dbg_req_ready && dbgGrantCycle == 0) begin
        dbgGrantCycle = c;
        csr_rdata = 32'h9;
        @(posedge clock);
        #1;
        dbg_req_valid = 1'b0;
      end
    end
    checkOutput("tie core rsp cycle", coreRspCycle, 32'd3);
    checkOutput("tie core rsp count", coreRspCount, 32'd1);
    checkOutput("tie core rdata", coreRdata, 32'h5);
    checkOutput("tie dbg grant cycle", dbgGrantCycle, 32'd4);
    checkOutput("tie dbg rsp cycle", dbgRspCycle, 32'd7);
    checkOutput("tie dbg rsp count", dbgRspCount, 32'd1);
    checkOutput("tie dbg rdata", dbgRdata, 32'h9);
    checkOutput("tie wen count", wenCount, 32'd2);
    checkOutput("tie wdata core", wdata1, 32'h11);
    checkOutput("tie wdata dbg", wdata2, 32'h22);

    // Debug was granted last, so the next tie goes to the core again.
    @(negedge clock);
    driveReq(1'b0, 2'b10, 12'hB02, 32'h0, 1'b1);
    driveReq(1'b1, 2'b10, 12'hB02, 32'h0, 1'b1);
    #1;
    checkOutput("tie second round grant", {30'd0, dbg_req_ready, core_req_ready}, 32'd1);
    @(posedge clock);
    #1;
    core_req_valid = 1'b0;
    dbg_req_valid  = 1'b0;
    repeat (4) @(negedge clock);

    // Reset landing in WRITE: write strobe drops at once and no response follows.
    @(negedge clock);
    csr_rdata = 32'hFF;
    driveReq(1'b0, 2'b11, 12'hB80, 32'hF0, 1'b0);
    @(posedge clock);
    #1;
    core_req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checkOutput("abort wen before reset", {31'd0, csr_wen}, 32'd1);
    checkOutput("abort wdata before reset", csr_wdata, 32'h0F);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("abort wen after reset", {31'd0, csr_wen}, 32'd0);
    checkOutput("abort wdata after reset", csr_wdata, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    quietBad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (csr_wen || core_rsp_valid || dbg_rsp_valid) quietBad = 1'b1;
    end
    checkOutput("abort no write or response", {31'd0, quietBad}, 32'd0);

    // Debug request withdrawn while the controller is busy leaves no trace.
    @(negedge clock);
    csr_rdata = 32'h2;
    driveReq(1'b0, 2'b01, 12'hB00, 32'hAB, 1'b0);
    @(posedge clock);
    #1;
    core_req_valid = 1'b0;
    driveReq(1'b1, 2'b01, 12'hB02, 32'h77, 1'b0);
    wenCount = 0; coreRspCount = 0; dbgRspCount = 0; quietBad = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if (dbg_req_ready) quietBad = 1'b1;
      if (c == 2) dbg_req_valid = 1'b0;
      if (csr_wen) begin wenCount++; wdata1 = csr_wdata; end
      if (core_rsp_valid) coreRspCount++;
      if (dbg_rsp_valid)  dbgRspCount++;
    end
    checkOutput("cancel dbg never ready", {31'd0, quietBad}, 32'd0);
    checkOutput("cancel wen count", wenCount, 32'd1);
    checkOutput("cancel core wdata", wdata1, 32'hAB);
    checkOutput("cancel core rsp count", coreRspCount, 32'd1);
    checkOutput("cancel dbg rsp count", dbgRspCount, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/csr_ctrl.md
CSR_CTRL -- requirements
Module: csr_ctrl

Interface
REQ-001 SHALL have clock  input  1  system clock; all state changes on rising edge.
REQ-002 SHALL have reset  input  1  asynchronous, active-high.
REQ-003 SHALL have core_req_valid/dbg_req_valid  input  1 each  request pending from core/debug.
REQ-004 SHALL have core_req_ready/dbg_req_ready  output  1 each  request accepted this cycle.
REQ-005 SHALL have core_req_op/dbg_req_op  input  2 each  csr_op_t: 01 RW, 10 RS, 11 RC, 00 reserved.
REQ-006 SHALL have core_req_addr/dbg_req_addr  input  12 each  CSR address.
REQ-007 SHALL have core_req_wdata/dbg_req_wdata  input  REG_W each  operand (register or zero-extended immediate).
REQ-008 SHALL have core_req_nowrite/dbg_req_nowrite  input  1 each  source is x0/zero-imm; suppresses write for RS/RC.
REQ-009 SHALL have core_rsp_valid/dbg_rsp_valid  output  1 each  one-cycle response pulse.
REQ-010 SHALL have core_rsp_rdata/dbg_rsp_rdata  output  REG_W each  pre-modification CSR value.
REQ-011 SHALL have core_rsp_illegal/dbg_rsp_illegal  output  1 each  access rejected.
REQ-012 SHALL have csr_addr  output  12, csr_wen  output  1, csr_wdata  output  REG_W  CSR file port; csr_rdata  input  REG_W  combinational read data.

Function
REQ-013 SHALL implement FSM IDLE -> READ -> (WRITE) -> RESP -> IDLE.
REQ-014 IDLE: SHALL assert ready to exactly one valid requester, chosen by arbiter, and capture its op/addr/wdata/nowrite; ready SHALL be 0 in all other states.
REQ-015 Arbitration SHALL be two-way round-robin: on simultaneous valid, grant the requester not granted last; single valid always wins.
REQ-016 READ: SHALL drive csr_addr with captured address, register csr_rdata as old value, compute new value and legality.
REQ-017 New value SHALL be RW: wdata; RS: old | wdata; RC: old & ~wdata; full REG_W width, no carries.
REQ-018 Write intent SHALL be 1 for RW, and for RS/RC only when nowrite=0.
REQ-019 Illegal SHALL be set for: op 00; address outside {0x301, 0xF11, 0xF12, 0xB00, 0xB80, 0xB02, 0xB82}; write intent with addr[11:10]=2'b11.
REQ-020 From READ, SHALL go to WRITE if write intent and legal, else RESP.
REQ-021 WRITE: SHALL assert csr_wen for exactly one cycle with csr_addr held and csr_wdata = new value.
REQ-022 RESP: SHALL pulse rsp_valid of owning requester only, rdata = old value (0 if illegal), illegal flag; other requester's outputs SHALL stay 0.
REQ-023 Latency accept-to-response SHALL be 3 cycles with write, 2 without; next acceptance earliest cycle after RESP.
REQ-024 A requester SHALL hold valid and request fields until ready; deassertion before ready SHALL cancel with no side effects.
REQ-025 csr_wen SHALL never assert for an illegal or no-write access.

Reset
REQ-026 On reset SHALL enter IDLE asynchronously; csr_wen, all ready, rsp_valid, rsp_illegal 0; rsp_rdata, csr_wdata, csr_addr 0; last-grant = debug (core wins first tie).
REQ-027 Reset mid-operation SHALL abort with no write and no response.

Structure
REQ-028 csr_op_t and the CSR address constants SHALL live in shared package csr_defines; REG_W_END from reg_defines.
REQ-029 Round-robin arbiter SHALL be sub-module csr_rr_arb (2 requests, grant, last-grant state).

Verification
REQ-030 Core RW addr 0xB00 wdata 0x1234, csr_rdata 0x10 -> csr_wen at T+2 with 0x1234, core_rsp at T+3 rdata 0x10 illegal 0.
REQ-031 Core RS addr 0xB02 nowrite=1, csr_rdata 0x7 -> no csr_wen, rsp at T+2 rdata 0x7 illegal 0.
REQ-032 Dbg RW addr 0xF11 -> no csr_wen, dbg_rsp illegal 1; addr 0x123 RS nowrite=1 -> illegal 1, rdata 0.
REQ-033 Core and dbg valid together for two transactions -> core granted first, dbg second, responses routed to correct port only.
REQ-034 Core RC addr 0xB80 wdata 0xF0, csr_rdata 0xFF -> csr_wdata 0x0F; reset asserted in WRITE -> csr_wen drops immediately, no response.
